// File: rtl/cordic_job_sequencer.sv
// Queues CORDIC jobs in a small FIFO and runs them one at a time through an external
// CORDIC unit, with a per-job completion timeout and a held result record.
module cordic_job_sequencer #(
    parameter int N       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_y,
    input  logic [N-1:0] in_z,
    input  logic         in_mode,
    output logic         cordic_start,
    output logic [N-1:0] cordic_xi,
    output logic [N-1:0] cordic_yi,
    output logic [N-1:0] cordic_zi,
    output logic         cordic_rot_vec,
    input  logic [N-1:0] cordic_xr,
    input  logic [N-1:0] cordic_yr,
    input  logic [N-1:0] cordic_zr,
    input  logic         cordic_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_x,
    output logic [N-1:0] out_y,
    output logic [N-1:0] out_z,
    output logic         out_mode,
    output logic         out_timeout,
    output logic         busy,
    output logic [7:0]   timeout_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
        logic         mode;
    } job_t;

    state_t          state;
    state_t          state_nx;
    job_t            mem [DEPTH];
    job_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ready_en;
    logic [TW-1:0]   timer;
    logic            done_q;
    logic            push;
    logic            pop;
    logic            fin_ok;
    logic            fin_to;
    logic            drive_ops;

    // Valid/ready: a transfer happens on a rising clk edge where both are high; the
    // source holds its payload stable while valid is high and ready is low.
    assign in_ready  = ready_en && (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = fin_ok || fin_to;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);
    assign drive_ops = (state == ISSUE) || (state == WAIT);

    assign cordic_xi      = drive_ops ? head.x    : '0;
    assign cordic_yi      = drive_ops ? head.y    : '0;
    assign cordic_zi      = drive_ops ? head.z    : '0;
    assign cordic_rot_vec = drive_ops ? head.mode : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A push in IDLE goes straight to ISSUE; the entry is readable at the head next cycle.
    always_comb begin
        state_nx     = state;
        cordic_start = 1'b0;
        out_valid    = 1'b0;
        fin_ok       = 1'b0;
        fin_to       = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) || push) state_nx = ISSUE;
            end
            ISSUE: begin
                cordic_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (cordic_done && !done_q) begin
                    fin_ok   = 1'b1;
                    state_nx = HOLD;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    fin_to   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{x: in_x, y: in_y, z: in_z, mode: in_mode};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // done_q tracks the raw input so a level left high by an earlier job never counts as a new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= cordic_done;
            if (state == ISSUE)     timer <= '0;
            else if (state == WAIT) timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            out_mode    <= 1'b0;
            out_timeout <= 1'b0;
            timeout_cnt <= '0;
        end else if (fin_ok) begin
            out_x       <= cordic_xr;
            out_y       <= cordic_yr;
            out_z       <= cordic_zr;
            out_mode    <= head.mode;
            out_timeout <= 1'b0;
        end else if (fin_to) begin
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            out_mode    <= head.mode;
            out_timeout <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Directed bench for cordic_job_sequencer: a behavioural CORDIC stand-in plus a
// result scoreboard; each scenario checks timing and payload against hand-derived values.
module tb_cordic_job_sequencer;
    localparam int N  = 32;
    localparam int EW = 3 * N + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic         in_mode = 1'b0;
    logic         cordic_start;
    logic [N-1:0] cordic_xi, cordic_yi, cordic_zi;
    logic         cordic_rot_vec;
    logic [N-1:0] cordic_xr, cordic_yr, cordic_zr;
    logic         cordic_done;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_x, out_y, out_z;
    logic         out_mode, out_timeout;
    logic         busy;
    logic [7:0]   timeout_cnt;

    cordic_job_sequencer #(.N(N), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_mode(in_mode),
        .cordic_start(cordic_start),
        .cordic_xi(cordic_xi), .cordic_yi(cordic_yi), .cordic_zi(cordic_zi),
        .cordic_rot_vec(cordic_rot_vec),
        .cordic_xr(cordic_xr), .cordic_yr(cordic_yr), .cordic_zr(cordic_zr),
        .cordic_done(cordic_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_mode(out_mode), .out_timeout(out_timeout),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int start_cnt = 0;
    int ov_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cordic_start) start_cnt <= start_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- CORDIC stand-in ----------------
    // Results are the operands plus 1/2/3 so a wrong capture source is visible.
    int   model_lat = 4;
    bit   model_never = 1'b0;
    bit   done_force = 1'b0;
    int   model_ctr = 0;
    logic model_done = 1'b0;

    assign cordic_xr   = cordic_xi + N'(1);
    assign cordic_yr   = cordic_yi + N'(2);
    assign cordic_zr   = cordic_zi + N'(3);
    assign cordic_done = model_done | done_force;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            model_ctr  = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (cordic_start) begin
                model_ctr = model_never ? 0 : model_lat;
            end else if (model_ctr > 0) begin
                model_ctr = model_ctr - 1;
                if (model_ctr == 0) model_done = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int push_cyc = 0;
    int out_cyc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_job(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z,
                            input logic mode, input logic to);
        int n;
        n = 0;
        in_x = x; in_y = y; in_z = z; in_mode = mode; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_stall", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        push_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        if (to) exp_q.push_back({mode, 1'b1, {(3 * N){1'b0}}});
        else    exp_q.push_back({mode, 1'b0, x + N'(1), y + N'(2), z + N'(3)});
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, out_valid, 1);
        out_cyc = cyc;
    endtask

    task automatic take_out(input string tag);
        logic [EW-1:0] exp_v;
        wait_out({tag, "_valid"}, 300);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, exp_q.size(), 1);
        end else begin
            exp_v = exp_q.pop_front();
            check(tag, {out_mode, out_timeout, out_x, out_y, out_z}, exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int s;
        int st0;
        int t0;
        int r;
        int snap;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_start", cordic_start, 0);
        check("rst_ops", {cordic_xi, cordic_yi, cordic_zi, cordic_rot_vec}, 0);
        check("rst_out", {out_x, out_y, out_z, out_mode, out_timeout}, 0);
        check("rst_tcnt", timeout_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        // Rotation job, done 20 cycles after start.
        model_lat = 20;
        push_job(32'h33333333, 32'h0CCCCCCD, 32'h2182A470, 1'b0, 1'b0);
        s = cyc;
        st0 = start_cnt;
        check("t1_start_pulse", cordic_start, 1);
        check("t1_ops", {cordic_xi, cordic_yi, cordic_zi, cordic_rot_vec},
              {32'h33333333, 32'h0CCCCCCD, 32'h2182A470, 1'b0});
        @(negedge clk);
        check("t1_start_one_cycle", cordic_start, 0);
        repeat (8) @(negedge clk);
        check("t1_ops_stable", {cordic_xi, cordic_yi, cordic_zi}, {32'h33333333, 32'h0CCCCCCD, 32'h2182A470});
        check("t1_no_early_out", out_valid, 0);
        wait_out("t1_valid", 100);
        check("t1_latency", out_cyc, s + 21);
        repeat (3) @(negedge clk);
        check("t1_hold_stable", {out_x, out_y, out_z}, {32'h33333334, 32'h0CCCCCCF, 32'h2182A473});
        check("t1_timeout_flag", out_timeout, 0);
        take_out("t1_result");
        check("t1_start_count", start_cnt - st0, 1);
        check("t1_out_drop", out_valid, 0);
        check("t1_idle", busy, 0);

        // Vectoring job.
        model_lat = 5;
        push_job(32'h26666666, 32'h33333333, 32'h00000000, 1'b1, 1'b0);
        check("t2_rot_vec_issue", cordic_rot_vec, 1);
        repeat (3) @(negedge clk);
        check("t2_rot_vec_wait", cordic_rot_vec, 1);
        wait_out("t2_valid", 50);
        check("t2_out", {out_mode, out_x, out_y, out_z}, {1'b1, 32'h26666667, 32'h33333335, 32'h00000003});
        take_out("t2_result");

        // Five back-to-back pushes against a four-entry FIFO.
        model_lat = 10;
        for (int i = 0; i < 4; i++) begin
            push_job(32'h10000000 + i, 32'h20000000 + i, 32'h30000000 + i, i[0], 1'b0);
            if (i == 0) t0 = push_cyc;
        end
        check("t3_ready_full", in_ready, 0);
        push_job(32'h10000004, 32'h20000004, 32'h30000004, 1'b0, 1'b0);
        check("t3_ready_after_pop", push_cyc, t0 + 12);
        for (int i = 0; i < 5; i++) take_out($sformatf("t3_result%0d", i));
        check("t3_drained", busy, 0);

        // Timeout: CORDIC never answers.
        model_never = 1'b1;
        push_job(32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 1'b1, 1'b1);
        s = cyc;
        check("t4_start", cordic_start, 1);
        wait_out("t4_valid", 100);
        check("t4_latency", out_cyc, s + 65);
        check("t4_tcnt", timeout_cnt, 1);
        take_out("t4_result");
        model_never = 1'b0;
        model_lat = 3;
        push_job(32'h00001234, 32'h00005678, 32'h00009ABC, 1'b0, 1'b0);
        take_out("t4_next_result");
        check("t4_tcnt_kept", timeout_cnt, 1);

        // done held high from one job into the next.
        model_lat = 4;
        push_job(32'h00000100, 32'h00000200, 32'h00000300, 1'b0, 1'b0);
        push_job(32'h00000400, 32'h00000500, 32'h00000600, 1'b1, 1'b0);
        wait_out("t5a_seen", 30);
        done_force = 1'b1;
        model_never = 1'b1;
        take_out("t5a_result");
        repeat (12) @(negedge clk);
        check("t5_held_done_ignored", out_valid, 0);
        check("t5_b_in_flight", busy, 1);
        done_force = 1'b0;
        @(negedge clk);
        done_force = 1'b1;
        r = cyc;
        wait_out("t5b_seen", 20);
        check("t5b_latency", out_cyc, r + 1);
        take_out("t5b_result");
        done_force = 1'b0;
        model_never = 1'b0;

        // Reset while a job waits and two more are queued.
        model_never = 1'b1;
        push_job(32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 1'b0, 1'b0);
        push_job(32'h0000DDDD, 32'h0000EEEE, 32'h0000FFFF, 1'b1, 1'b0);
        push_job(32'h00001111, 32'h00002222, 32'h00003333, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("t6_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_ops", {cordic_xi, cordic_yi, cordic_zi, cordic_rot_vec, cordic_start}, 0);
        check("t6_rst_flags", {busy, in_ready, out_valid}, 0);
        check("t6_rst_out", {out_x, out_y, out_z, out_mode, out_timeout}, 0);
        check("t6_rst_tcnt", timeout_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_never = 1'b0;
        snap = ov_cnt;
        repeat (80) @(negedge clk);
        check("t6_no_output", ov_cnt, snap);
        check("t6_idle", busy, 0);
        model_lat = 6;
        push_job(32'h7FFFFFFF, 32'h80000000, 32'h00000042, 1'b1, 1'b0);
        check("t6_next_start", cordic_start, 1);
        take_out("t6_result");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_job_sequencer.md
CORDIC_JOB_SEQUENCER -- requirements
Module: cordic_job_sequencer

Interface
REQ-001 Parameter N, default 32, operand/result width (signed, Q-format opaque to this block).
REQ-002 Parameter DEPTH, default 4, job FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT, default 64, max cycles waited for cordic_done per job.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1 / in_ready  output  1  job-push handshake; push when both high.
REQ-007 in_x, in_y, in_z  input  N each  job operands; in_mode  input  1  0 = rotation, 1 = vectoring.
REQ-008 cordic_start  output  1  one-cycle start pulse to the CORDIC unit.
REQ-009 cordic_xi, cordic_yi, cordic_zi  output  N each; cordic_rot_vec  output  1  operands/mode to CORDIC.
REQ-010 cordic_xr, cordic_yr, cordic_zr  input  N each; cordic_done  input  1  CORDIC results and completion.
REQ-011 out_valid  output  1 / out_ready  input  1  result handshake; transfer when both high.
REQ-012 out_x, out_y, out_z  output  N each; out_mode  output  1; out_timeout  output  1  result record.
REQ-013 busy  output  1  high when FSM not in IDLE or FIFO non-empty.
REQ-014 timeout_cnt  output  8  count of timed-out jobs, saturating at 255.

Function
REQ-015 FIFO: DEPTH entries of {x,y,z,mode}; in_ready = (count < DEPTH); push and pop in the same cycle allowed, count unchanged.
REQ-016 Push while full is impossible (in_ready low); in_valid with in_ready low has no effect.
REQ-017 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-018 IDLE -> ISSUE when FIFO non-empty; else remain.
REQ-019 ISSUE lasts exactly one cycle: cordic_start = 1, then -> WAIT; wait timer cleared to 0.
REQ-020 cordic_xi/yi/zi/rot_vec driven from FIFO head, stable from ISSUE through end of WAIT; zero in IDLE/HOLD.
REQ-021 cordic_done registered every cycle into done_q; job completes in WAIT on cycle where cordic_done=1 and done_q=0 (rising edge); level-high done carried over from a previous job is ignored.
REQ-022 On completion: capture cordic_xr/yr/zr into out_x/y/z, out_mode = head mode, out_timeout = 0, pop FIFO, -> HOLD.
REQ-023 Timer increments each WAIT cycle; if no completion and timer = TIMEOUT-1: out_x/y/z = 0, out_mode = head mode, out_timeout = 1, pop FIFO, timeout_cnt += 1 (saturating), -> HOLD.
REQ-024 Completion and timeout on the same cycle: completion wins, out_timeout = 0, timeout_cnt unchanged.
REQ-025 HOLD: out_valid = 1, outputs stable until out_ready; on transfer -> IDLE. out_valid = 0 in all other states.
REQ-026 Minimum job latency: push at cycle t -> ISSUE t+1 (if idle, FIFO write visible next cycle), done rising edge at cycle d -> out_valid at d+1.
REQ-027 Jobs processed strictly in push order; one job in flight at a time.
REQ-028 cordic_done outside WAIT has no effect other than updating done_q.

Reset
REQ-029 rst asserted: FSM -> IDLE, FIFO empty, count 0, timer 0, done_q 0, timeout_cnt 0, immediately (asynchronously).
REQ-030 During reset: in_ready 0, cordic_start 0, cordic operands 0, out_valid 0, out_x/y/z/mode/timeout 0, busy 0.
REQ-031 in_ready = 1 from the first clock edge after rst deasserts; reset mid-job discards all queued and in-flight jobs with no output.

Verification
REQ-032 Rotation job x=0x33333333, y=0x0CCCCCCD, z=0x2182A470, mode 0, model returns done after 20 cycles -> single cordic_start pulse, cordic operands match, out_valid with model results, out_timeout 0.
REQ-033 Vectoring job x=0x26666666, y=0x33333333, z=0, mode 1 -> cordic_rot_vec 1 throughout WAIT, out_mode 1, results passed through unchanged.
REQ-034 Push 5 jobs back-to-back with CORDIC stalled -> in_ready drops after 4 (DEPTH) accepted, rises after first pop; all 5 results emerge in order.
REQ-035 Model never asserts done, TIMEOUT=64 -> out_valid exactly 64 cycles after WAIT entry, out_timeout 1, out_x/y/z 0, timeout_cnt 1; next job still issues normally.
REQ-036 done held high across two jobs (no low cycle) -> second job not completed until done falls and rises again, or times out.
REQ-037 rst pulsed during WAIT with 3 jobs queued -> all outputs zero immediately, no out_valid after release, next pushed job processed normally.
